// File: rtl/eth_rx.sv
// eth_rx: delimits SOF/length/payload/checksum frames from a byte stream and
// buffers the payload in a first-word-fall-through FIFO with per-frame status.
module eth_rx #(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 1500,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, PAYLOAD, CSUM} state_t;
  state_t state, nxt;
  logic [7:0] len_h, sum;
  logic [15:0] len, rem;
  logic [TW-1:0] tcnt;
  logic ovf, timeout, push, ok_n, err_n, wr, rd;
  logic [AW:0] count;
  logic [AW-1:0] wp, rp;
  logic [8:0] mem [DEPTH];
  assign len = {len_h, rx_data};
  assign wr = push && count != FULL;
  assign rd = out_valid && out_ready;
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rp][7:0] : 8'h00;
  assign out_last = out_valid && mem[rp][8];
  assign busy = state != IDLE;
  assign timeout = busy && !rx_valid && tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    push = 1'b0;
    ok_n = 1'b0;
    err_n = 1'b0;
    if (timeout) begin
      nxt = IDLE;
      err_n = 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE: nxt = rx_data == 8'hD5 ? LEN_H : IDLE;
        LEN_H: nxt = LEN_L;
        LEN_L: begin
          err_n = len > 16'(MAX_LEN);
          nxt = err_n ? IDLE : len == 16'd0 ? CSUM : PAYLOAD;
        end
        PAYLOAD: begin
          push = 1'b1;
          nxt = rem == 16'd1 ? CSUM : PAYLOAD;
        end
        CSUM: begin
          ok_n = rx_data == sum && !ovf;
          err_n = !ok_n;
          nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_h <= '0;
      rem <= '0;
      sum <= '0;
      ovf <= 1'b0;
      tcnt <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= '0;
      count <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= nxt;
      frame_ok <= ok_n;
      frame_err <= err_n;
      tcnt <= (rx_valid || !busy || timeout) ? '0 : tcnt + 1'b1;
      // a dropped push poisons the whole frame until the FSM is back in IDLE
      ovf <= nxt == IDLE ? 1'b0 : ovf | (push && !wr);
      if (err_n && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      if (rx_valid && state == LEN_H) len_h <= rx_data;
      if (rx_valid && state == LEN_L) begin
        rem <= len;
        sum <= '0;
      end
      if (push) begin
        rem <= rem - 1'b1;
        sum <= sum + rx_data;
      end
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(wr) - (AW + 1)'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= {rem == 16'd1, rx_data};
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: scenario tasks plus randomized frames checked against a queue-based frame model.
module tb_eth_rx;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] out_data, err_cnt;
  logic out_last, out_valid, frame_ok, frame_err, busy;
  int n_chk = 0, n_fail = 0;
  logic [8:0] rx_q[$], exp_q[$];
  bit st_q[$], exp_st[$];
  logic [7:0] tx_q[$];
  eth_rx dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
    if (frame_ok) st_q.push_back(1'b1);
    if (frame_err) st_q.push_back(1'b0);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask
  task automatic send_q(input int max_gap);
    while (tx_q.size() > 0) begin
      idle($urandom_range(0, max_gap));
      @(posedge clk);
      #1 rx_data = tx_q.pop_front();
      rx_valid = 1'b1;
    end
    idle(1);
  endtask
  task automatic add_frame(input int len, input bit good);
    int s = 0;
    logic [7:0] b;
    tx_q.push_back(8'hD5);
    tx_q.push_back(len[15:8]);
    tx_q.push_back(len[7:0]);
    if (len > 1500) begin
      exp_st.push_back(1'b0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s += b;
      tx_q.push_back(b);
      exp_q.push_back({i == len - 1, b});
    end
    tx_q.push_back(good ? 8'(s) : 8'(s + $urandom_range(1, 255)));
    exp_st.push_back(good);
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({out_valid, out_last, out_data} !== 10'h0) begin n_fail++; $display("FAIL reset_out: got %h want 000", {out_valid, out_last, out_data}); end
    n_chk++; if ({frame_ok, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", {frame_ok, frame_err}); end
    n_chk++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_good_frame;
    rx_q.delete();
    out_ready = 1'b1;
    tx_q = '{8'hD5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_q(0);
    n_chk++; if ({frame_ok, frame_err} !== 2'b10) begin n_fail++; $display("FAIL good_pulse: got %b want 10", {frame_ok, frame_err}); end
    idle(1);
    n_chk++; if (frame_ok !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width: got %b want 0", frame_ok); end
    idle(3);
    n_chk++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL good_count: got %0d want 3", rx_q.size()); end
    n_chk++; if ({rx_q[0], rx_q[1], rx_q[2]} !== {9'h011, 9'h022, 9'h133}) begin n_fail++; $display("FAIL good_bytes: got %h %h %h want 011 022 133", rx_q[0], rx_q[1], rx_q[2]); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt); end
  endtask
  task automatic test_bad_csum;
    rx_q.delete();
    tx_q = '{8'hD5, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_q(0);
    n_chk++; if ({frame_ok, frame_err} !== 2'b01) begin n_fail++; $display("FAIL bad_pulse: got %b want 01", {frame_ok, frame_err}); end
    idle(3);
    n_chk++; if (rx_q.size() != 2 || {rx_q[0], rx_q[1]} !== {9'h0AA, 9'h155}) begin n_fail++; $display("FAIL bad_bytes: got %0d entries %h %h want 0aa 155", rx_q.size(), rx_q[0], rx_q[1]); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL bad_err_cnt: got %0d want 1", err_cnt); end
    repeat (40) begin
      tx_q = '{8'hD5, 8'h00, 8'h00, 8'h01};
      send_q(1);
    end
    idle(2);
    n_chk++; if (err_cnt !== 8'd41) begin n_fail++; $display("FAIL bad_err_cnt_41: got %0d want 41", err_cnt); end
  endtask
  task automatic test_zero_oversize;
    rx_q.delete();
    tx_q = '{8'hD5, 8'h00, 8'h00, 8'h00};
    send_q(0);
    n_chk++; if ({frame_ok, frame_err} !== 2'b10) begin n_fail++; $display("FAIL zero_pulse: got %b want 10", {frame_ok, frame_err}); end
    idle(2);
    n_chk++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL zero_no_push: got %0d want 0", rx_q.size()); end
    tx_q = '{8'hD5, 8'h05, 8'hDD};
    send_q(0);
    n_chk++; if ({frame_err, busy} !== 2'b10) begin n_fail++; $display("FAIL oversize: got err,busy=%b want 10", {frame_err, busy}); end
    tx_q = '{8'hD5, 8'h00, 8'h01, 8'h7E, 8'h7E};
    send_q(0);
    n_chk++; if ({frame_ok, frame_err} !== 2'b10) begin n_fail++; $display("FAIL after_oversize_pulse: got %b want 10", {frame_ok, frame_err}); end
    idle(2);
    n_chk++; if (rx_q.size() != 1 || rx_q[0] !== 9'h17E) begin n_fail++; $display("FAIL after_oversize_byte: got %0d entries %h want 17e", rx_q.size(), rx_q[0]); end
  endtask
  task automatic test_overflow;
    logic [7:0] pay[20];
    int s = 0;
    rx_q.delete();
    out_ready = 1'b0;
    tx_q = '{8'hD5, 8'h00, 8'd20};
    for (int i = 0; i < 20; i++) begin
      pay[i] = 8'($urandom);
      s += pay[i];
      tx_q.push_back(pay[i]);
    end
    tx_q.push_back(8'(s));
    send_q(0);
    n_chk++; if ({frame_ok, frame_err} !== 2'b01) begin n_fail++; $display("FAIL ovf_pulse: got %b want 01", {frame_ok, frame_err}); end
    out_ready = 1'b1;
    idle(22);
    n_chk++; if (rx_q.size() != 16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", rx_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (rx_q[i] !== {1'b0, pay[i]}) begin n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], {1'b0, pay[i]}); end
    end
  endtask
  task automatic test_timeout_junk;
    logic [7:0] e0;
    st_q.delete();
    rx_q.delete();
    e0 = err_cnt;
    tx_q = '{8'h00, 8'hFF, 8'h12};
    send_q(0);
    idle(2);
    n_chk++; if (busy !== 1'b0 || st_q.size() != 0 || err_cnt !== e0) begin n_fail++; $display("FAIL junk: got busy=%b pulses=%0d err_cnt=%0d want 0 0 %0d", busy, st_q.size(), err_cnt, e0); end
    tx_q = '{8'hD5, 8'h00, 8'h04, 8'h11};
    send_q(0);
    idle(254);
    n_chk++; if ({busy, frame_err} !== 2'b10) begin n_fail++; $display("FAIL timeout_early: got busy,err=%b want 10", {busy, frame_err}); end
    idle(1);
    n_chk++; if ({busy, frame_err} !== 2'b01) begin n_fail++; $display("FAIL timeout: got busy,err=%b want 01", {busy, frame_err}); end
    idle(2);
    n_chk++; if (err_cnt !== 8'(e0 + 1)) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d want %0d", err_cnt, 8'(e0 + 1)); end
    n_chk++; if (rx_q.size() != 1 || rx_q[0] !== 9'h011) begin n_fail++; $display("FAIL timeout_kept: got %0d entries %h want 011", rx_q.size(), rx_q[0]); end
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b0;
    tx_q = '{8'hD5, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03};
    send_q(0);
    n_chk++; if ({out_valid, busy} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got valid,busy=%b want 11", {out_valid, busy}); end
    st_q.delete();
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({out_valid, out_data, busy, err_cnt} !== 18'h0) begin n_fail++; $display("FAIL mid_reset: got valid=%b data=%h busy=%b err_cnt=%0d want all 0", out_valid, out_data, busy, err_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    n_chk++; if (st_q.size() != 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d pulses want 0", st_q.size()); end
    rx_q.delete();
    out_ready = 1'b1;
    tx_q = '{8'hD5, 8'h00, 8'h02, 8'hC3, 8'h3C, 8'hFF};
    send_q(0);
    n_chk++; if (frame_ok !== 1'b1) begin n_fail++; $display("FAIL mid_after_ok: got %b want 1", frame_ok); end
    idle(3);
    n_chk++; if (rx_q.size() != 2 || {rx_q[0], rx_q[1]} !== {9'h0C3, 9'h13C}) begin n_fail++; $display("FAIL mid_after_bytes: got %0d entries %h %h want 0c3 13c", rx_q.size(), rx_q[0], rx_q[1]); end
  endtask
  task automatic test_random;
    int errs = 0;
    logic [7:0] j;
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
    exp_st.delete();
    out_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      j = 8'($urandom);
      if ($urandom_range(0, 2) == 0 && j != 8'hD5) tx_q.push_back(j);
      add_frame($urandom_range(0, 7) == 0 ? $urandom_range(1501, 65535) : $urandom_range(0, 20), 1'($urandom));
      send_q(3);
    end
    idle(5);
    foreach (exp_st[i]) if (!exp_st[i]) errs++;
    n_chk++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_chk++; if (st_q.size() != exp_st.size()) begin n_fail++; $display("FAIL rand_status_count: got %0d want %0d", st_q.size(), exp_st.size()); end
    foreach (exp_st[i]) begin
      n_chk++; if (st_q[i] !== exp_st[i]) begin n_fail++; $display("FAIL rand_status%0d: got %b want %b", i, st_q[i], exp_st[i]); end
    end
    n_chk++; if (err_cnt !== 8'(errs > 255 ? 255 : errs)) begin n_fail++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, errs); end
  endtask
  task automatic test_saturate;
    repeat (300) begin
      tx_q = '{8'hD5, 8'hFF, 8'hFF};
      send_q(0);
    end
    idle(2);
    n_chk++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate: got %0d want 255", err_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL saturate_busy: got %b want 0", busy); end
  endtask
  initial begin
    test_reset;
    test_good_frame;
    test_bad_csum;
    test_zero_oversize;
    test_overflow;
    test_timeout_junk;
    test_reset_mid;
    test_random;
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
